icache_dm: RTL and testbench

Direct-mapped, read-only instruction cache between the pipeline fetch stage and the memory controller. The fetch stage presents `imemREN`/`imemaddr` and stalls on `ihit` low. On a miss, the cache fills a two-word block from memory through a blocking `iREN`/`iwait` handshake. Hits return the instruction in the same cycle.

---
 rtl/icache_dm.sv | 150 +++++++++++++++
 tb/tb_icache_dm.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with two-word blocks and a blocking fill.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache_dm #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX = $clog2(SETS);
    localparam int TAG = 29 - IDX;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH0 = 2'd1,
        FETCH1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [TAG-1:0]     miss_tag_q, miss_tag_d;
    logic [IDX-1:0]     miss_idx_q, miss_idx_d;
    logic [TAG-1:0]     tag_q   [SETS];
    logic [TAG-1:0]     tag_d   [SETS];
    logic [31:0]        data0_q [SETS];
    logic [31:0]        data0_d [SETS];
    logic [31:0]        data1_q [SETS];
    logic [31:0]        data1_d [SETS];

    logic [IDX-1:0]     req_idx;
    logic [TAG-1:0]     req_tag;
    logic               req_off;
    logic               lookup_hit;
    logic               unused_addr_bits;

    assign req_off          = imemaddr[2];
    assign req_idx          = imemaddr[2+IDX:3];
    assign req_tag          = imemaddr[31:3+IDX];
    assign unused_addr_bits = ^imemaddr[1:0];
    assign lookup_hit       = imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        miss_tag_d = miss_tag_q;
        miss_idx_d = miss_idx_q;
        tag_d      = tag_q;
        data0_d    = data0_q;
        data1_d    = data1_q;
        ihit       = 1'b0;
        imemload   = 32'd0;
        iREN       = 1'b0;
        iaddr      = 32'd0;
        case (state_q)
            IDLE: begin
                ihit = lookup_hit;
                if (lookup_hit) begin
                    imemload = req_off ? data1_q[req_idx] : data0_q[req_idx];
                end else if (imemREN) begin
                    miss_tag_d = req_tag;
                    miss_idx_d = req_idx;
                    state_d    = FETCH0;
                end
            end
            FETCH0: begin
                iREN  = 1'b1;
                iaddr = {miss_tag_q, miss_idx_q, 3'b000};
                if (!iwait) begin
                    data0_d[miss_idx_q] = iload;
                    state_d             = FETCH1;
                end
            end
            FETCH1: begin
                iREN  = 1'b1;
                iaddr = {miss_tag_q, miss_idx_q, 3'b100};
                // Tag and valid only land with the last word, so a half-filled set never hits.
                if (!iwait) begin
                    data1_d[miss_idx_q] = iload;
                    tag_d[miss_idx_q]   = miss_tag_q;
                    valid_d[miss_idx_q] = 1'b1;
                    state_d             = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
        end
    end

    always_ff @(posedge CLK) begin
        tag_q   <= tag_d;
        data0_q <= data0_d;
        data1_q <= data1_d;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (ihit && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if ((state_q == IDLE) && (state_d == FETCH0) && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: a block-level cache model with timing arithmetic checked every cycle,
// plus directed scenarios with literal expectations.
module tb_icache_dm;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_dm #(.SETS(16)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hDEAD_0000;
    endfunction

    // Memory: holds iwait high for lat cycles on each new word request, then returns mem_word.
    logic        prev_ren  = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    int          wcnt      = 0;
    initial begin
        iwait = 1'b0;
        iload = 32'd0;
        forever begin
            @(posedge CLK);
            #1;
            if (iREN) begin
                if (!prev_ren || iaddr != prev_addr) wcnt = 0;
                else wcnt++;
                iwait = (wcnt < lat);
                iload = iwait ? 32'hBAD0_BAD0 : mem_word(iaddr);
            end else begin
                iwait = 1'($urandom_range(0, 1));
                iload = $urandom;
            end
            prev_ren  = iREN;
            prev_addr = iaddr;
        end
    end

    // Model: which block address each set holds, and where the current fill is in time.
    logic        m_valid [16];
    logic [28:0] m_blk   [16];
    bit          busy     = 1'b0;
    int          k        = 0;
    logic [31:0] base     = 32'd0;
    logic [31:0] m_hits   = 32'd0;
    logic [31:0] m_misses = 32'd0;

    initial begin
        for (int s = 0; s < 16; s++) begin
            m_valid[s] = 1'b0;
            m_blk[s]   = '0;
        end
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                for (int s = 0; s < 16; s++) m_valid[s] = 1'b0;
                busy     = 1'b0;
                m_hits   = 32'd0;
                m_misses = 32'd0;
                chk("m_rst_iren", iREN, 32'd0);
                chk("m_rst_ihit", ihit, 32'd0);
            end else begin
`ifdef ICACHE_STATS_EN
                chk("m_hit_count", hit_count, m_hits);
                chk("m_miss_count", miss_count, m_misses);
`endif
                if (busy) begin
                    k++;
                    chk("m_fill_iren", iREN, 32'd1);
                    chk("m_fill_iaddr", iaddr, (k <= lat + 1) ? base : (base | 32'd4));
                    chk("m_fill_ihit", ihit, 32'd0);
                    chk("m_fill_load", imemload, 32'd0);
                    if (k == 2 * lat + 2) begin
                        m_valid[base[6:3]] = 1'b1;
                        m_blk[base[6:3]]   = base[31:3];
                        busy = 1'b0;
                    end
                end else begin
                    logic e_hit;
                    e_hit = imemREN && m_valid[imemaddr[6:3]] && (m_blk[imemaddr[6:3]] == imemaddr[31:3]);
                    chk("m_ihit", ihit, e_hit);
                    chk("m_load", imemload, e_hit ? mem_word(imemaddr) : 32'd0);
                    chk("m_idle_iren", iREN, 32'd0);
                    chk("m_idle_iaddr", iaddr, 32'd0);
                    if (e_hit) begin
                        if (m_hits != 32'hFFFF_FFFF) m_hits++;
                    end else if (imemREN) begin
                        busy = 1'b1;
                        k    = 0;
                        base = {imemaddr[31:3], 3'b000};
                        if (m_misses != 32'hFFFF_FFFF) m_misses++;
                    end
                end
            end
        end
    end

    task automatic wait_hit(input string name, output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!ihit && cyc < 60);
        chk(name, ihit, 32'd1);
    endtask

    task automatic drive(input logic ren, input logic [31:0] addr);
        @(posedge CLK);
        #2;
        imemREN  = ren;
        imemaddr = addr;
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int cyc;
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'd0;
        repeat (2) @(negedge CLK);
        chk("reset_ihit", ihit, 32'd0);
        chk("reset_iren", iREN, 32'd0);
        chk("reset_iaddr", iaddr, 32'd0);
        chk("reset_load", imemload, 32'd0);
`ifdef ICACHE_STATS_EN
        chk("reset_hits", hit_count, 32'd0);
        chk("reset_misses", miss_count, 32'd0);
`endif
        @(posedge CLK);
        #2;
        nRST = 1'b1;

        // cold miss at 0x40 with zero memory latency
        lat = 0;
        drive(1'b1, 32'h40);
        @(negedge CLK); chk("cold_c0_ihit", ihit, 32'd0);
        @(negedge CLK); chk("cold_c1_iren", iREN, 32'd1); chk("cold_c1_iaddr", iaddr, 32'h40);
        @(negedge CLK); chk("cold_c2_iaddr", iaddr, 32'h44);
        @(negedge CLK); chk("cold_c3_ihit", ihit, 32'd1); chk("cold_c3_load", imemload, 32'hDEAD_0040);

        drive(1'b1, 32'h44);
        @(negedge CLK);
        chk("same_blk_ihit", ihit, 32'd1);
        chk("same_blk_load", imemload, 32'hDEAD_0044);
        chk("same_blk_iren", iREN, 32'd0);

        // conflict on set 0
        drive(1'b1, 32'h00);
        @(negedge CLK); chk("conf_00_miss", ihit, 32'd0);
        wait_hit("conf_00_fill", cyc); chk("conf_00_lat", cyc, 32'd3);
        drive(1'b1, 32'h80);
        @(negedge CLK); chk("conf_80_miss", ihit, 32'd0);
        wait_hit("conf_80_fill", cyc); chk("conf_80_lat", cyc, 32'd3);
        chk("conf_80_load", imemload, 32'hDEAD_0080);
        drive(1'b1, 32'h00);
        @(negedge CLK); chk("conf_00_again_miss", ihit, 32'd0);
        wait_hit("conf_00_again_fill", cyc);

        // fresh reset, then three wait cycles per word
        drive(1'b0, 32'h0);
        nRST = 1'b0;
        @(negedge CLK);
        drive(1'b1, 32'h100);
        nRST = 1'b1;
        lat  = 3;
        @(negedge CLK); chk("l3_c0_ihit", ihit, 32'd0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            chk("l3_iren_held", iREN, 32'd1);
        end
        @(negedge CLK);
        chk("l3_c9_ihit", ihit, 32'd1);
        chk("l3_c9_load", imemload, 32'hDEAD_0100);
`ifdef ICACHE_STATS_EN
        chk("l3_miss_count", miss_count, 32'd1);
`endif

        // reset during the second word of a fill at 0x200
        drive(1'b1, 32'h200);
        @(negedge CLK); chk("rmid_c0_ihit", ihit, 32'd0);
        repeat (6) @(negedge CLK);
        chk("rmid_c6_iaddr", iaddr, 32'h204);
        #2;
        nRST = 1'b0;
        #1;
        chk("rmid_iren_drop", iREN, 32'd0);
        @(negedge CLK);
        @(posedge CLK);
        #2;
        nRST = 1'b1;
        @(negedge CLK); chk("rmid_refetch_miss", ihit, 32'd0);
        wait_hit("rmid_refill", cyc);
        chk("rmid_refill_lat", cyc, 32'd9);
        chk("rmid_refill_load", imemload, 32'hDEAD_0200);

        // no requests: nothing moves, whatever the address
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 32'h200 + 32'(i * 4));
            @(negedge CLK);
            chk("noreq_iren", iREN, 32'd0);
            chk("noreq_ihit", ihit, 32'd0);
        end
`ifdef ICACHE_STATS_EN
        chk("noreq_hits", hit_count, 32'd1);
        chk("noreq_misses", miss_count, 32'd1);
`endif

        // stalled fetch: each cycle of a held hit counts
        drive(1'b1, 32'h204);
        repeat (3) begin
            @(negedge CLK);
            chk("stall_ihit", ihit, 32'd1);
        end
        drive(1'b0, 32'h0);
        @(negedge CLK);
`ifdef ICACHE_STATS_EN
        chk("stall_hits", hit_count, 32'd4);
`endif
        chk("end_iren", iREN, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
